// File: rtl/corelet_in_stage.sv
// rtl/corelet_in_stage.sv - staged WS/OS vector buffer with diagonal skew for the MAC array west edge
module corelet_in_stage #(
  parameter int row     = 8,
  parameter int bw      = 4,
  parameter int depth   = 16,
  parameter int loop_bw = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mode,
  input  logic                         wr,
  input  logic [bw*row-1:0]            in,
  input  logic                         start,
  input  logic [loop_bw-1:0]           loops,
  input  logic                         clr,
  output logic [bw*row-1:0]            out,
  output logic [row-1:0]               out_valid,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         busy,
  output logic                         done,
  output logic                         wr_err
);

  localparam int CW = $clog2(depth + 1);
  localparam int PW = $clog2(depth);
  localparam int DW = $clog2(row) + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [bw*row-1:0]   mem_q [depth];
  logic [CW-1:0]       count_q, n_q, ptr_q, last_ptr;
  logic [loop_bw-1:0]  pass_q;
  logic                mode_q, done_q, wr_err_q;
  logic [DW-1:0]       dcnt_q;
  logic [bw*row-1:0]   pipe_data_q [row];
  logic [row-1:0]      pipe_vld_q;
  logic                full_w, wr_acc, start_acc, issue, last_slot, finish;

  assign full_w = (count_q == CW'(depth));

  // Next-state and per-cycle strobes: accepted write/start in IDLE, slot issue in STREAM, drain countdown
  always_comb begin
    state_d   = state_q;
    wr_acc    = 1'b0;
    start_acc = 1'b0;
    issue     = 1'b0;
    last_slot = 1'b0;
    finish    = 1'b0;
    last_ptr  = n_q - CW'(1);
    case (state_q)
      IDLE: begin
        if (!clr) begin
          wr_acc = wr && !full_w;
          if (start && (count_q != '0 || wr_acc)) begin
            start_acc = 1'b1;
            state_d   = STREAM;
          end
        end
      end
      STREAM: begin
        issue     = 1'b1;
        last_slot = (ptr_q == last_ptr) && (pass_q == '0);
        if (last_slot) begin
          if (row == 1) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (dcnt_q == DW'(1)) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers: occupancy, latched stream parameters, read pointer, pass and drain counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      n_q      <= '0;
      ptr_q    <= '0;
      pass_q   <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      dcnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= finish;
      if (wr && (state_q != IDLE || (!clr && full_w))) wr_err_q <= 1'b1;
      if (state_q == IDLE && clr) count_q <= '0;
      else if (wr_acc) count_q <= count_q + CW'(1);
      else if (finish && !mode_q) count_q <= '0;
      if (start_acc) begin
        n_q    <= count_q + CW'(wr_acc);
        ptr_q  <= '0;
        pass_q <= mode ? loops : '0;
        mode_q <= mode;
      end
      if (issue) begin
        if (ptr_q == last_ptr) begin
          ptr_q  <= '0;
          pass_q <= pass_q - loop_bw'(1);
        end else begin
          ptr_q <= ptr_q + CW'(1);
        end
      end
      if (last_slot) dcnt_q <= DW'(row - 1);
      else if (state_q == DRAIN) dcnt_q <= dcnt_q - DW'(1);
    end
  end

  // Vector storage; contents survive reset and clr, only the occupancy count is cleared
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem_q[count_q[PW-1:0]] <= in;
  end

  // Skew pipeline: stage k holds the vector issued k cycles earlier, lane k taps stage k
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < row; k++) pipe_data_q[k] <= '0;
      pipe_vld_q <= '0;
    end else begin
      pipe_data_q[0] <= issue ? mem_q[ptr_q[PW-1:0]] : '0;
      pipe_vld_q[0]  <= issue;
      for (int k = 1; k < row; k++) begin
        pipe_data_q[k] <= pipe_data_q[k-1];
        pipe_vld_q[k]  <= pipe_vld_q[k-1];
      end
    end
  end

  // Output taps and status decode
  always_comb begin
    out = '0;
    for (int r = 0; r < row; r++) out[bw*r +: bw] = pipe_data_q[r][bw*r +: bw];
  end

  assign out_valid = pipe_vld_q;
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = (count_q == '0);
  assign busy      = (state_q != IDLE) || done_q;
  assign done      = done_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_corelet_in_stage.sv
// tb/tb_corelet_in_stage.sv - randomized and directed checks of corelet_in_stage against a slot-schedule model
module tb_corelet_in_stage;

  localparam int ROW   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 16;
  localparam int LBW   = 4;
  localparam int MAXC  = 8192;

  logic        clk = 1'b0;
  logic        reset, mode, wr, start, clr;
  logic [31:0] din;
  logic [3:0]  loops;
  logic [31:0] out;
  logic [7:0]  out_valid;
  logic [4:0]  count;
  logic        full, empty, busy, done, wr_err;

  corelet_in_stage #(.row(ROW), .bw(BW), .depth(DEPTH), .loop_bw(LBW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .wr(wr), .in(din), .start(start),
    .loops(loops), .clr(clr), .out(out), .out_valid(out_valid), .count(count),
    .full(full), .empty(empty), .busy(busy), .done(done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   ecnt = 0;
  bit   chk_en = 0;

  // Model: expected lane data/valid per cycle, buffered entries, stream window [m_e0, m_ed]
  logic [31:0] exp_d [MAXC];
  logic [7:0]  exp_v [MAXC];
  logic [31:0] m_mem [DEPTH];
  int          m_cnt = 0;
  int          m_e0 = -100;
  int          m_ed = -100;
  bit          m_ws = 0;
  bit          m_err = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, ecnt, act, expv);
    end
  endtask

  // Apply the rules to the inputs seen at this rising edge; cycle ecnt follows it
  task automatic model_edge();
    int n, p, s, idx;
    ecnt++;
    if (reset) begin
      m_cnt = 0; m_err = 0; m_e0 = -100; m_ed = -100; m_ws = 0;
      for (int k = ecnt; k < MAXC; k++) begin exp_d[k] = '0; exp_v[k] = '0; end
      return;
    end
    if (m_ws && ecnt == m_ed) m_cnt = 0;
    if (ecnt - 1 >= m_e0 && ecnt - 1 < m_ed) begin
      if (wr) m_err = 1;
    end else if (clr) begin
      m_cnt = 0;
    end else begin
      if (wr) begin
        if (m_cnt < DEPTH) begin m_mem[m_cnt] = din; m_cnt++; end
        else m_err = 1;
      end
      if (start && m_cnt > 0) begin
        n = m_cnt;
        p = mode ? int'(loops) + 1 : 1;
        s = n * p;
        m_e0 = ecnt;
        m_ed = ecnt + s + ROW - 1;
        m_ws = !mode;
        for (int j = 0; j < s; j++)
          for (int r = 0; r < ROW; r++) begin
            idx = ecnt + 1 + j + r;
            if (idx < MAXC) begin
              exp_d[idx][BW*r +: BW] = m_mem[j % n][BW*r +: BW];
              exp_v[idx][r] = 1'b1;
            end
          end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    chk_en = 1;
    #1;
  endtask

  // Compare every cycle against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en && ecnt < MAXC) begin
      chk("out", out, exp_d[ecnt]);
      chk("out_valid", out_valid, exp_v[ecnt]);
      chk("count", count, m_cnt);
      chk("full", full, m_cnt == DEPTH);
      chk("empty", empty, m_cnt == 0);
      chk("busy", busy, ecnt >= m_e0 && ecnt <= m_ed);
      chk("done", done, ecnt == m_ed);
      chk("wr_err", wr_err, m_err);
    end
  end

  task automatic do_write(logic [31:0] d);
    wr = 1; din = d; tick(); wr = 0;
  endtask

  task automatic do_start(bit md, int lp);
    mode = md; loops = 4'(lp); start = 1; tick(); start = 0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (ecnt <= m_ed && guard < 2000) begin tick(); guard++; end
    if (guard >= 2000) chk("wait_idle_timeout", 1, 0);
  endtask

  logic [31:0] e [3];
  logic [31:0] f [16];
  int          e0, k, nw, guard;

  initial begin
    for (int i = 0; i < MAXC; i++) begin exp_d[i] = '0; exp_v[i] = '0; end
    mode = 0; loops = 0; clr = 0;
    reset = 1; wr = 1; start = 1; din = 32'h12345678;
    tick(); tick();
    reset = 0; wr = 0; start = 0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wr_err", wr_err, 0);

    // WS skew
    do_write(32'h76543210); do_write(32'hFEDCBA98); do_start(0, 0); e0 = ecnt;
    for (int i = 0; i < 12; i++) begin
      tick(); k = ecnt - e0;
      case (k)
        1: begin chk("ws_l0_s0", out[3:0], 4'h0); chk("ws_v0_s0", out_valid[0], 1); end
        2: chk("ws_l0_s1", out[3:0], 4'h8);
        8: begin chk("ws_l7_s0", out[31:28], 4'h7); chk("ws_done_early", done, 0); end
        9: begin chk("ws_l7_s1", out[31:28], 4'hF); chk("ws_done", done, 1); end
        default: ;
      endcase
    end
    chk("ws_count_after", count, 0);

    // OS replay and restart
    for (int i = 0; i < 3; i++) begin e[i] = $urandom; do_write(e[i]); end
    do_start(1, 2); e0 = ecnt;
    for (int i = 0; i < 20; i++) begin
      tick(); k = ecnt - e0;
      if (k >= 1 && k <= 9) chk("os_l0_seq", out[3:0], e[(k-1)%3][3:0]);
      if (k == 16) chk("os_done", done, 1);
    end
    chk("os_count_kept", count, 3);
    do_start(1, 2); wait_idle();
    chk("os_count_kept2", count, 3);

    // Full / overflow
    clr = 1; tick(); clr = 0;
    for (int i = 0; i < 16; i++) begin f[i] = $urandom; do_write(f[i]); end
    do_write(32'hDEADBEEF);
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 16);
    chk("ovf_wr_err", wr_err, 1);
    do_start(0, 0); e0 = ecnt;
    for (int i = 0; i < 24; i++) begin
      tick(); k = ecnt - e0;
      if (k == 16) chk("ovf_e15_l0", out[3:0], f[15][3:0]);
      if (k == 23) chk("ovf_e15_l7", out[31:28], f[15][31:28]);
    end
    wait_idle();

    // wr+start same cycle with count=2
    do_write($urandom); do_write($urandom);
    wr = 1; din = $urandom; mode = 0; start = 1; tick(); wr = 0; start = 0; e0 = ecnt;
    for (int i = 0; i < 12; i++) begin
      tick(); k = ecnt - e0;
      if (k == 9) chk("ws3_done_early", done, 0);
      if (k == 10) chk("ws3_done", done, 1);
    end

    // clr+start same cycle
    do_write($urandom); do_write($urandom);
    clr = 1; start = 1; tick(); clr = 0; start = 0;
    chk("clrst_count", count, 0);
    chk("clrst_busy", busy, 0);
    tick();
    chk("clrst_busy2", busy, 0);

    // Reset mid-stream, then normal operation
    reset = 1; tick(); reset = 0;
    do_write($urandom); do_write($urandom); do_start(1, 3);
    tick(); tick(); tick();
    reset = 1; tick(); reset = 0;
    chk("mrst_out", out, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_count", count, 0);
    for (int i = 0; i < 20; i++) tick();
    do_write($urandom); do_start(0, 0); wait_idle();

    // Write during STREAM
    do_write($urandom); do_write($urandom); do_write($urandom);
    do_start(0, 0); tick();
    wr = 1; din = $urandom; tick(); wr = 0;
    chk("strm_wr_err", wr_err, 1);
    wait_idle();

    // Randomized traffic
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 7) == 0) begin reset = 1; tick(); reset = 0; end
      if ($urandom_range(0, 3) == 0) begin clr = 1; tick(); clr = 0; end
      nw = $urandom_range(0, 17);
      for (int i = 0; i < nw; i++) begin
        wr = ($urandom_range(0, 4) != 0); din = $urandom; tick();
      end
      wr = $urandom_range(0, 1); din = $urandom;
      mode = $urandom_range(0, 1); loops = 4'($urandom_range(0, 3));
      clr = ($urandom_range(0, 9) == 0);
      start = 1; tick(); start = 0; clr = 0;
      guard = 0;
      while (ecnt <= m_ed && guard < 2000) begin
        wr = ($urandom_range(0, 9) == 0); din = $urandom; tick(); guard++;
      end
      wr = 0;
      if (guard >= 2000) chk("rand_timeout", 1, 0);
    end
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/corelet_in_stage.md
Name: corelet_in_stage

Overview:
- Parametrised successor to the corelet's L0/ififo input path: one buffer stages activation/weight vectors for the MAC array's west edge, in either WS or OS mode.
- WS mode (mode=0): the buffered tile is streamed once and consumed.
- OS mode (mode=1): the buffered tile is replayed a programmable number of times and retained, which replaces the ad-hoc ififo self-reset looping.
- Output is diagonally skewed per row and carries per-row valids, so it feeds mac_array in_w directly.

Parameters:
- row, 8, number of array rows / lanes per vector
- bw, 4, bits per lane element
- depth, 16, vector entries held (≥2)
- loop_bw, 4, width of the replay-count field

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- mode  input  1  0=WS, 1=OS; sampled on accepted start
- wr  input  1  write one vector
- in  input  bw*row  vector to write; lane r = in[bw*(r+1)-1:bw*r]
- start  input  1  begin streaming
- loops  input  loop_bw  OS extra passes (total passes = loops+1); sampled on accepted start
- clr  input  1  discard buffered contents
- out  output  bw*row  skewed lane outputs
- out_valid  output  row  per-lane valid
- count  output  $clog2(depth+1)  entries held
- full  output  1  count==depth
- empty  output  1  count==0
- busy  output  1  streaming or draining
- done  output  1  one-cycle completion pulse
- wr_err  output  1  sticky: a write was dropped

Behaviour:
- Reset (synchronous, sampled on clk rising edge):
  - count, out, out_valid, busy, done, wr_err = 0; empty=1; state=IDLE.
  - Reset asserted mid-stream aborts immediately; no done pulse.
- States: IDLE, STREAM, DRAIN.
- IDLE:
  - wr & !full: entry[count] <= in; count+1.
  - wr & full: write dropped; wr_err <= 1.
  - clr: count <= 0. clr has priority over wr and start in the same cycle.
  - start & (count>0 or wr accepted same cycle): latch mode and loops; N = count after that cycle's write; go to STREAM.
  - start with nothing buffered: ignored, no done.
- Writes in STREAM/DRAIN are dropped and set wr_err. clr and start are ignored outside IDLE.
- STREAM:
  - One issue slot per cycle, back-to-back, no bubbles. Read pointer 0..N-1 per pass.
  - WS: one pass, S=N slots.
  - OS: loops+1 passes, pointer wraps N-1 → 0 with no gap; S=N*(loops+1).
  - After slot S-1 is issued, go to DRAIN.
- DRAIN:
  - Waits row-1 cycles so the skew pipeline empties. row=1: zero DRAIN cycles.
  - On exit: done=1 for one cycle, then IDLE.
  - WS: count <= 0 in the cycle done is high.
  - OS: count and entries are unchanged, so the same tile can be restarted.
- Skew and latency:
  - Start accepted at edge E0. Slot j lane r appears on out lane r with out_valid[r]=1 in the cycle after edge E0+1+j+r.
  - Lane 0 of slot 0 is visible 1 cycle after E0.
  - Lanes not carrying a valid slot output 0 with valid 0.
- busy=1 from the cycle after E0 through the done cycle inclusive.
- done coincides with out_valid[row-1] of slot S-1.
- count/full/empty are registered and reflect accepted writes one cycle after the write edge.
- OS replay count width: the slot counter must hold depth*2^loop_bw without overflow.

Test Plan:
- Reset: assert reset 2 cycles with wr=1, start=1 → count=0, empty=1, busy=0, out_valid=0, wr_err=0.
- WS skew, row=8, bw=4: write vectors A=0x76543210, B=0xFEDCBA98, start mode=0 →
  - lane0 shows 0 then 8 in cycles 1–2 after start;
  - lane7 shows 7 then F in cycles 8–9;
  - done in cycle 9; count=0 afterwards.
- OS replay: 3 entries, loops=2, mode=1 →
  - lane0 sequence e0,e1,e2 repeated 3 times with no gaps (9 valid cycles);
  - done at cycle 9+7;
  - count remains 3; a second start replays identical data.
- Full/overflow: 16 writes then a 17th → full=1, count=16, wr_err=1; entry 15 intact when streamed.
- Simultaneous events:
  - wr+start same cycle with count=2 → 3 slots streamed.
  - clr+start same cycle → count=0, no busy.
  - wr during STREAM → dropped, wr_err=1.
- Reset mid-stream: reset 3 cycles into an OS stream → all outputs 0 next cycle, no done pulse; a new write+start then behaves normally.
